// File: rtl/mult_rr_scheduler_pkg.sv
// Shared definitions for the round-robin multiplier scheduler: FSM encoding,
// default sizes and the requester-index width helper.
package mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int L_WORD_DEF = 4;
  localparam int N_REQ_DEF  = 4;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_rr_scheduler_arbiter.sv
// Combinational rotating-priority arbiter: the first set request above ptr
// (wrapping modulo N_REQ) wins; outputs a one-hot grant and the winner index.
module rr_arbiter_comb #(
  parameter int N_REQ = 4,
  parameter int L_idx = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [L_idx-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [L_idx-1:0] idx
);

  logic [L_idx-1:0] rot_idx [N_REQ];
  logic [N_REQ-1:0] rot_req;

  // Position gi of the rotated view is requester (ptr + 1 + gi) mod N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [L_idx:0] sum;
    assign sum = {1'b0, ptr} + (L_idx + 1)'(gi + 1);
    assign rot_idx[gi] = (sum >= (L_idx + 1)'(N_REQ)) ?
                         L_idx'(sum - (L_idx + 1)'(N_REQ)) : sum[L_idx-1:0];
    assign rot_req[gi] = req[rot_idx[gi]];
  end

  always_comb begin
    idx   = '0;
    grant = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) idx = rot_idx[k];
    end
    if (|req) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one shift-add multiplier among N_REQ requesters with round-robin
// arbitration. Optional MULT_ZERO_BYPASS_EN skips the multiplier for zero operands.
module mult_rr_scheduler
  import mult_pkg::*;
#(
  parameter int L_word = L_WORD_DEF,
  parameter int N_REQ  = N_REQ_DEF,
  parameter int L_idx  = idx_width(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*L_word-1:0] word1_in,
  input  logic [N_REQ*L_word-1:0] word2_in,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [2*L_word-1:0]     product_out,
  output logic                    busy,
  output logic                    mult_start,
  output logic [L_word-1:0]       mult_word1,
  output logic [L_word-1:0]       mult_word2,
  input  logic                    mult_ready,
  input  logic [2*L_word-1:0]     mult_product
);

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [L_idx-1:0]    owner_q, owner_d;
  logic [L_idx-1:0]    ptr_q, ptr_d;
  logic [2*L_word-1:0] product_q, product_d;
  logic [L_word-1:0]   word1_q, word1_d;
  logic [L_word-1:0]   word2_q, word2_d;

  logic [N_REQ-1:0]    arb_grant;
  logic [L_idx-1:0]    arb_idx;
  logic [L_word-1:0]   sel_word1, sel_word2;

  rr_arbiter_comb #(
    .N_REQ (N_REQ),
    .L_idx (L_idx)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign sel_word1 = word1_in[arb_idx*L_word +: L_word];
  assign sel_word2 = word2_in[arb_idx*L_word +: L_word];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    product_d = product_q;
    word1_d   = word1_q;
    word2_d   = word2_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = arb_grant;
          owner_d = arb_idx;
          word1_d = sel_word1;
          word2_d = sel_word2;
`ifdef MULT_ZERO_BYPASS_EN
          if (sel_word1 == '0 || sel_word2 == '0) begin
            product_d = '0;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
`else
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE:  state_d = ST_SETTLE;
      // Ready may still be stale from the previous product; skip one cycle.
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mult_ready) begin
          product_d = mult_product;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        ptr_d   = owner_q;
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= L_idx'(N_REQ - 1);
      product_q <= '0;
      word1_q   <= '0;
      word2_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      product_q <= product_d;
      word1_q   <= word1_d;
      word2_q   <= word2_d;
    end
  end

  assign grant       = grant_q;
  assign done        = (state_q == ST_DONE) ? grant_q : '0;
  assign product_out = product_q;
  assign busy        = (state_q != ST_IDLE);
  assign mult_start  = (state_q == ST_ISSUE);
  assign mult_word1  = word1_q;
  assign mult_word2  = word2_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler driving a behavioural 4-bit shift-add
// multiplier; vector table plus hand sequences for contention, reset and fairness.
module tb_mult_rr_scheduler;

  localparam int LW = 4;
  localparam int NR = 4;
`ifdef MULT_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 4;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NR-1:0] req = '0;
  logic [15:0]   word1_in = '0;
  logic [15:0]   word2_in = '0;
  logic [NR-1:0] grant, done;
  logic [7:0]    product_out;
  logic          busy, mult_start;
  logic [3:0]    mult_word1, mult_word2;
  logic          mult_ready;
  logic [7:0]    mult_product;

  always #5 clock = ~clock;

  mult_rr_scheduler #(.L_word(LW), .N_REQ(NR), .L_idx(2)) dut (
    .clock(clock), .reset(reset), .req(req),
    .word1_in(word1_in), .word2_in(word2_in),
    .grant(grant), .done(done), .product_out(product_out), .busy(busy),
    .mult_start(mult_start), .mult_word1(mult_word1), .mult_word2(mult_word2),
    .mult_ready(mult_ready), .mult_product(mult_product)
  );

  // Behavioural multiplier: zero operands keep Ready high with product 0,
  // otherwise Ready drops for LW cycles while partial products accumulate.
  logic [7:0] m_acc, m_a, m_acc_n;
  logic [3:0] m_b;
  int         m_cnt;
  assign m_acc_n = m_acc + (m_b[0] ? m_a : 8'd0);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mult_ready <= 1'b1; mult_product <= '0;
      m_acc <= '0; m_a <= '0; m_b <= '0; m_cnt <= 0;
    end else if (mult_start) begin
      if (mult_word1 == 4'd0 || mult_word2 == 4'd0) begin
        mult_product <= '0; mult_ready <= 1'b1;
      end else begin
        mult_ready <= 1'b0; m_acc <= '0;
        m_a <= {4'b0, mult_word1}; m_b <= mult_word2; m_cnt <= LW;
      end
    end else if (m_cnt > 0) begin
      m_acc <= m_acc_n; m_a <= m_a << 1; m_b <= m_b >> 1; m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mult_product <= m_acc_n; mult_ready <= 1'b1;
      end
    end
  end

  int start_cnt = 0;
  always @(posedge clock) if (mult_start) start_cnt <= start_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock); @(negedge clock);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 30) begin cyc(); k++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // Waits for a done pulse; cycles counts the cycles waited (-1 on timeout).
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin cyc(); cycles++; end while (done == '0 && cycles < 30);
    if (done == '0) cycles = -1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] w1;
    logic [15:0] w2;
    int          idx;
    int          prod;
    int          lat;
  } vec_t;

  // Issue one request at cycle t, drop it and scramble operands after grant.
  task automatic run_vec(input string tag, input vec_t v);
    int s0, lat;
    wait_idle();
    req = v.req; word1_in = v.w1; word2_in = v.w2; s0 = start_cnt;
    cyc();
    lat = 1;
    chk({tag, "_grant"}, int'(grant), 1 << v.idx);
    chk({tag, "_start_t1"}, int'(mult_start), (v.lat == 1) ? 0 : 1);
    req = '0; word1_in = 16'($urandom); word2_in = 16'($urandom);
    while (done == '0 && lat < 30) begin cyc(); lat++; end
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_done"}, int'(done), 1 << v.idx);
    chk({tag, "_product"}, int'(product_out), v.prod);
    chk({tag, "_starts"}, start_cnt - s0, (v.lat == 1) ? 0 : 1);
    $display("%s: idx %0d product %0d latency %0d", tag, v.idx, product_out, lat);
    cyc();
    chk({tag, "_done_one_cycle"}, int'(done), 0);
  endtask

  vec_t vecs [9];

  initial begin
    int lat, cnt;
    int order [5];
    int cprod [4];

    vecs[0] = '{4'b0100, 16'h0500, 16'h0700, 2, 35, 7};
    vecs[1] = '{4'b0010, 16'h0000, 16'h0090, 1, 0, ZLAT};
    vecs[2] = '{4'b1000, 16'hF000, 16'hF000, 3, 225, 7};
    vecs[3] = '{4'b1010, 16'h2030, 16'h2060, 1, 18, 7};
    vecs[4] = '{4'b1010, 16'h9030, 16'hB060, 3, 99, 7};
    vecs[5] = '{4'b0001, 16'h000C, 16'h0000, 0, 0, ZLAT};
    vecs[6] = '{4'b1111, 16'h1275, 16'h1386, 1, 56, 7};
    vecs[7] = '{4'b0101, 16'h0100, 16'h0D00, 2, 13, 7};
    vecs[8] = '{4'b0001, 16'h000A, 16'h000A, 0, 100, 7};

    // Reset state
    cyc(); cyc();
    chk("rst_grant", int'(grant), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_start", int'(mult_start), 0);
    chk("rst_product", int'(product_out), 0);
    chk("rst_words", int'({mult_word1, mult_word2}), 0);
    reset = 1'b1;
    cyc();

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Contention: all requesters held from reset
    reset = 1'b0;
    req = 4'b1111; word1_in = 16'h263F; word2_in = 16'h975F;
    cprod[0] = 225; cprod[1] = 15; cprod[2] = 42; cprod[3] = 18;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_done(lat);
      chk($sformatf("cont%0d_found", i), int'(lat > 0), 1);
      chk($sformatf("cont%0d_done", i), int'(done), 1 << order[i]);
      chk($sformatf("cont%0d_product", i), int'(product_out), cprod[order[i]]);
      $display("cont%0d: done %b product %0d", i, done, product_out);
      cyc();
      chk($sformatf("cont%0d_idle_gap", i), int'(busy), 0);
      if (i == 4) req = '0;
    end

    // Reset asserted during WAIT
    wait_idle();
    req = 4'b0100; word1_in = 16'h0500; word2_in = 16'h0700;
    cyc();
    req = '0;
    cyc(); cyc(); cyc();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_grant", int'(grant), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_start", int'(mult_start), 0);
    chk("mid_rst_product", int'(product_out), 0);
    @(negedge clock);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin cyc(); if (done != '0) cnt++; end
    chk("mid_rst_no_done", cnt, 0);
    $display("reset mid-op: done pulses after release %0d", cnt);
    run_vec("post_rst", '{4'b0010, 16'h0030, 16'h0050, 1, 15, 7});

    // Fairness: requester 0 continuous, requester 2 joins mid-operation
    wait_idle();
    req = 4'b0001; word1_in = 16'h0B04; word2_in = 16'h0304;
    cyc(); cyc();
    req = 4'b0101;
    wait_done(lat);
    chk("fair_first", int'(done), 4'b0001);
    chk("fair_first_product", int'(product_out), 16);
    cyc();
    wait_done(lat);
    chk("fair_second", int'(done), 4'b0100);
    chk("fair_second_product", int'(product_out), 33);
    $display("fair: second done %b product %0d", done, product_out);
    cyc();
    wait_done(lat);
    chk("fair_third", int'(done), 4'b0001);
    req = '0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
